motor_encoder_decoder: RTL and testbench
========================================

// Module: motor_encoder_decoder
// PURPOSE
//  - Feedback path for the motor driver: decodes the motor's quadrature encoder (A/B) into position, direction and speed.
//  - Also flags stall while the motor is commanded to run (motor_signal=1).
//  - Sits beside the motor drive block; shares motor_signal; outputs feed LEDs/status logic.
// PARAMETERS
//  CNT_W          16     position counter width; wraps modulo 2^CNT_W
//  SPEED_W        16     edges-per-window width; saturates at 2^SPEED_W-1
//  WINDOW_CYCLES  50000  speed window length in clk cycles (1 ms at 50 MHz); >=2
//  STALL_WINDOWS  8      consecutive zero-edge windows while commanded before stall=1; >=1
//  FILT_LEN       3      consecutive equal synced samples needed to accept a new input level; >=1
// PORTS
//  clk           in   1        system clock; all logic on rising edge
//  n_rst         in   1        reset: synchronous, active-high
//  enc_a         in   1        encoder channel A, asynchronous
//  enc_b         in   1        encoder channel B, asynchronous
//  motor_signal  in   1        1 = motor commanded to run (enables stall detection)
//  clr           in   1        synchronous position clear
//  position      out  CNT_W    signed two's-complement position, in quadrature edges
//  dir           out  1        direction of last valid step: 1 = forward (CW), 0 = reverse
//  speed         out  SPEED_W  valid edges counted in the last completed window
//  speed_valid   out  1        1-cycle pulse when speed updates
//  stall         out  1        stall flag (level)
//  err           out  1        1-cycle pulse on illegal quadrature transition
// BEHAVIOUR
//  - Reset: all outputs 0; window counter, stall counter and edge counter 0; FSM -> INIT.
//  - Input path, per channel:
//    - 2-FF synchroniser, then a filter.
//    - Filtered level changes only after FILT_LEN consecutive identical synced samples.
//    - Input-to-filtered latency = 2+FILT_LEN cycles.
//  - FSM states: INIT, Q00, Q01, Q11, Q10 (state = filtered {A,B}).
//    - INIT: load state from the first filtered {A,B} after reset; no count, no err.
//  - Forward sequence 00->01->11->10->00:
//    - position +1, dir <= 1; registered 1 cycle after the filtered change.
//  - Reverse sequence:
//    - position -1, dir <= 0.
//  - Two-bit change (00<->11, 01<->10):
//    - err pulses 1 cycle; position and dir unchanged; FSM moves to the new state.
//    - The edge is not counted in speed.
//  - No change: hold.
//  - position wraps: 0x7FFF+1 -> 0x8000, 0x0000-1 -> 0xFFFF (CNT_W=16).
//  - clr: position <= 0 next cycle. clr wins over a same-cycle step; dir still updates.
//  - Speed window:
//    - Window counter runs 0..WINDOW_CYCLES-1 continuously.
//    - Valid steps (either direction) increment the edge counter, saturating.
//    - In the terminal cycle: speed <= edge count including any step in that cycle; speed_valid=1; edge count <= 0.
//  - Stall:
//    - At each window end with motor_signal=1: zero edges -> stall counter +1 (saturating); else stall counter <= 0.
//    - stall <= 1 when stall counter reaches STALL_WINDOWS.
//    - motor_signal=0 clears stall and the stall counter on the next cycle, regardless of window phase.
//  - Reset mid-operation: all state is discarded; FSM re-enters INIT, so no spurious step or err is produced.
// CONFIGURATION
//  - ENC_INDEX_EN defined:
//    - Adds input port enc_z (index pulse), filtered like A/B.
//    - Rising edge of filtered Z sets position <= 0 next cycle.
//    - Priority: n_rst > clr > index > step.
//  - ENC_INDEX_EN undefined:
//    - No enc_z port; position is cleared only by n_rst/clr.
// STRUCTURE
//  - Shared package motor_pkg:
//    - quadrature state encoding (Q00/Q01/Q11/Q10).
//    - MOTOR_CW / MOTOR_STOP drive codes.
//    - DIR_FWD/DIR_REV constants.
//  - Sub-module enc_input_filter (synchroniser + FILT_LEN filter, param FILT_LEN):
//    - one instance per channel (A, B, and Z when ENC_INDEX_EN).
//  - Top holds the FSM, position counter, speed window and stall logic.
// TESTING (FILT_LEN=3, WINDOW_CYCLES=100, STALL_WINDOWS=2, CNT_W=16)
//  - Reset, then drive forward sequence 00,01,11,10,00 (each held 10 cycles) -> position=4, dir=1, err never 1.
//  - From position 0, one reverse step -> position=0xFFFF, dir=0.
//  - From 0x7FFF, one forward step -> position=0x8000.
//  - Jump 00->11 -> err high exactly 1 cycle; position unchanged; next legal step from 11 counts normally.
//  - 2-cycle glitch on enc_a -> no position change.
//  - 7 forward steps in one window -> speed=7 with a 1-cycle speed_valid.
//  - motor_signal=1 with no edges -> stall=1 at the end of the 2nd window.
//  - motor_signal -> 0 -> stall=0 one cycle later.
//  - clr asserted in the same cycle as a forward step -> position=0.
//  - With ENC_INDEX_EN: Z rising edge at position 25 -> position=0.

Source files
------------

// File: rtl/motor_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
// Shared definitions for the motor driver and encoder feedback path.
//  - quad_state_e : quadrature decoder states (Q00/Q01/Q11/Q10 = filtered {A,B},
//                   plus Q_INIT while waiting for the first filtered sample)
//  - step_e       : classification of a filtered {A,B} transition
//  - MOTOR_CW / MOTOR_STOP : motor drive codes shared with the drive block
//  - DIR_FWD / DIR_REV     : direction output codes
//  - quad_phase / quad_step: Gray-to-phase conversion and step classification
// -----------------------------------------------------------------------------
package motor_pkg;

   typedef enum logic [2:0] {
      Q00    = 3'b000,
      Q01    = 3'b001,
      Q11    = 3'b011,
      Q10    = 3'b010,
      Q_INIT = 3'b100
   } quad_state_e;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_FWD  = 2'd1,
      STEP_REV  = 2'd2,
      STEP_ERR  = 2'd3
   } step_e;

   localparam logic MOTOR_CW   = 1'b1;
   localparam logic MOTOR_STOP = 1'b0;

   localparam logic DIR_FWD = 1'b1;
   localparam logic DIR_REV = 1'b0;

   // Map the Gray-coded {A,B} level onto its position in the forward cycle
   // 00 -> 0, 01 -> 1, 11 -> 2, 10 -> 3.
   function automatic logic [1:0] quad_phase(input logic [1:0] ab);
      return {ab[1], ab[1] ^ ab[0]};
   endfunction

   // The modulo-4 phase difference tells everything: +1 forward, -1 reverse,
   // 2 means both channels moved at once (illegal), 0 means no change.
   function automatic step_e quad_step(input logic [1:0] prev_ab,
                                       input logic [1:0] next_ab);
      logic [1:0] delta;
      delta = quad_phase(next_ab) - quad_phase(prev_ab);
      case (delta)
         2'd1:    return STEP_FWD;
         2'd3:    return STEP_REV;
         2'd2:    return STEP_ERR;
         default: return STEP_NONE;
      endcase
   endfunction

endpackage

// File: rtl/enc_input_filter.sv
// -----------------------------------------------------------------------------
// enc_input_filter
// Synchroniser plus level filter for one asynchronous encoder channel.
// The filtered level only moves after FILT_LEN consecutive identical synced
// samples, giving an input-to-output latency of 2+FILT_LEN cycles.
// Ports:
//  clk    in  system clock
//  n_rst  in  synchronous active-high reset
//  din    in  raw asynchronous encoder input
//  dout   out filtered level
//  valid  out 1 once dout holds a level actually seen on din since reset
// -----------------------------------------------------------------------------
module enc_input_filter
   import motor_pkg::*;
#(
   parameter int FILT_LEN = 3
) (
   input  logic clk,
   input  logic n_rst,
   input  logic din,
   output logic dout,
   output logic valid
);

   localparam int              RUN_W   = $clog2(FILT_LEN + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FILT_LEN);

   logic [1:0]       sync_r;     // [0] first stage, [1] second stage
   logic [1:0]       fill_r;     // marks which sync stages hold real samples
   logic             prev_r;     // previous synced sample
   logic [RUN_W-1:0] run_r;      // length of the current run of equal samples
   logic [RUN_W-1:0] run_now_s;
   logic             accept_s;
   logic             dout_r;
   logic             valid_r;

   // Run length including the sample currently at the synchroniser output.
   always_comb begin
      run_now_s = RUN_W'(1);
      if ((sync_r[1] == prev_r) && (run_r != {RUN_W{1'b0}})) begin
         if (run_r < RUN_MAX) begin
            run_now_s = run_r + RUN_W'(1);
         end else begin
            run_now_s = RUN_MAX;
         end
      end else begin
         run_now_s = RUN_W'(1);
      end
   end

   // Stale reset zeros in the synchroniser must never count toward a run.
   assign accept_s = fill_r[1] && (run_now_s == RUN_MAX);

   // Synchroniser, run tracking and filtered level register.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         sync_r  <= 2'b00;
         fill_r  <= 2'b00;
         prev_r  <= 1'b0;
         run_r   <= {RUN_W{1'b0}};
         dout_r  <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[0], din};
         fill_r <= {fill_r[0], 1'b1};
         if (fill_r[1]) begin
            prev_r <= sync_r[1];
            run_r  <= run_now_s;
         end
         if (accept_s) begin
            dout_r  <= sync_r[1];
            valid_r <= 1'b1;
         end
      end
   end

   assign dout  = dout_r;
   assign valid = valid_r;

endmodule

// File: rtl/motor_encoder_decoder.sv
// -----------------------------------------------------------------------------
// motor_encoder_decoder
// Quadrature encoder feedback: position, direction, speed and stall detection.
// Optional feature macro: ENC_INDEX_EN adds the enc_z index input; a rising
// edge of filtered Z clears the position (priority n_rst > clr > index > step).
// Ports:
//  clk           in   system clock
//  n_rst         in   synchronous active-high reset
//  enc_a, enc_b  in   asynchronous encoder channels
//  enc_z         in   asynchronous index pulse (ENC_INDEX_EN only)
//  motor_signal  in   1 = motor commanded to run, enables stall detection
//  clr           in   synchronous position clear
//  position      out  signed position in quadrature edges, wraps
//  dir           out  direction of last valid step, 1 = forward
//  speed         out  valid edges counted in the last completed window
//  speed_valid   out  1-cycle pulse when speed updates
//  stall         out  stall flag
//  err           out  1-cycle pulse on an illegal two-bit transition
// -----------------------------------------------------------------------------
module motor_encoder_decoder
   import motor_pkg::*;
#(
   parameter int CNT_W         = 16,
   parameter int SPEED_W       = 16,
   parameter int WINDOW_CYCLES = 50000,
   parameter int STALL_WINDOWS = 8,
   parameter int FILT_LEN      = 3
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    enc_a,
   input  logic                    enc_b,
`ifdef ENC_INDEX_EN
   input  logic                    enc_z,
`endif
   input  logic                    motor_signal,
   input  logic                    clr,
   output logic signed [CNT_W-1:0] position,
   output logic                    dir,
   output logic [SPEED_W-1:0]      speed,
   output logic                    speed_valid,
   output logic                    stall,
   output logic                    err
);

   localparam int                  WIN_W     = $clog2(WINDOW_CYCLES);
   localparam logic [WIN_W-1:0]    WIN_LAST  = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [SPEED_W-1:0]  SPEED_MAX = {SPEED_W{1'b1}};
   localparam int                  STALL_W   = $clog2(STALL_WINDOWS + 1);
   localparam logic [STALL_W-1:0]  STALL_LIM = STALL_W'(STALL_WINDOWS);

   logic a_filt_s, a_vld_s, b_filt_s, b_vld_s;
   logic index_s;

   quad_state_e state_r, next_state_s;
   step_e       step_s;
   logic [1:0]  cur_ab_s;
   logic [1:0]  new_ab_s;
   logic        valid_step_s;

   logic signed [CNT_W-1:0] position_r;
   logic                    dir_r;
   logic                    err_r;

   logic [WIN_W-1:0]   win_cnt_r;
   logic               win_end_s;
   logic [SPEED_W-1:0] edge_cnt_r;
   logic [SPEED_W-1:0] edge_inc_s;
   logic [SPEED_W-1:0] speed_r;
   logic               speed_valid_r;
   logic [STALL_W-1:0] stall_cnt_r;
   logic [STALL_W-1:0] stall_cnt_nx_s;
   logic               stall_r;

   enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
      .clk   (clk),
      .n_rst (n_rst),
      .din   (enc_a),
      .dout  (a_filt_s),
      .valid (a_vld_s)
   );

   enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
      .clk   (clk),
      .n_rst (n_rst),
      .din   (enc_b),
      .dout  (b_filt_s),
      .valid (b_vld_s)
   );

`ifdef ENC_INDEX_EN
   logic z_filt_s, z_vld_s;
   logic z_prev_r, z_armed_r;

   enc_input_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (
      .clk   (clk),
      .n_rst (n_rst),
      .din   (enc_z),
      .dout  (z_filt_s),
      .valid (z_vld_s)
   );

   // Previous filtered Z; armed only after the first real sample so a Z that
   // is already high out of reset is not mistaken for an index pulse.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         z_prev_r  <= 1'b0;
         z_armed_r <= 1'b0;
      end else if (z_vld_s) begin
         z_prev_r  <= z_filt_s;
         z_armed_r <= 1'b1;
      end
   end

   assign index_s = z_vld_s & z_armed_r & z_filt_s & ~z_prev_r;
`else
   assign index_s = 1'b0;
`endif

   assign new_ab_s = {a_filt_s, b_filt_s};
   assign cur_ab_s = state_r[1:0];

   // Quadrature state register.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         state_r <= Q_INIT;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next state and step classification; INIT only adopts the first filtered
   // level so a reset never yields a step or error.
   always_comb begin
      next_state_s = state_r;
      step_s       = STEP_NONE;
      case (state_r)
         Q_INIT: begin
            if (a_vld_s && b_vld_s) begin
               next_state_s = quad_state_e'({1'b0, new_ab_s});
            end else begin
               next_state_s = Q_INIT;
            end
         end
         Q00, Q01, Q11, Q10: begin
            step_s       = quad_step(cur_ab_s, new_ab_s);
            next_state_s = quad_state_e'({1'b0, new_ab_s});
         end
         default: begin
            next_state_s = Q_INIT;
            step_s       = STEP_NONE;
         end
      endcase
   end

   assign valid_step_s = (step_s == STEP_FWD) || (step_s == STEP_REV);

   // Position, direction and error pulse.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         position_r <= {CNT_W{1'b0}};
         dir_r      <= DIR_REV;
         err_r      <= 1'b0;
      end else begin
         if (clr || index_s) begin
            position_r <= {CNT_W{1'b0}};
         end else if (step_s == STEP_FWD) begin
            position_r <= position_r + CNT_W'(1);
         end else if (step_s == STEP_REV) begin
            position_r <= position_r - CNT_W'(1);
         end
         // Direction follows the step even when a clear wins the position.
         if (step_s == STEP_FWD) begin
            dir_r <= DIR_FWD;
         end else if (step_s == STEP_REV) begin
            dir_r <= DIR_REV;
         end
         err_r <= (step_s == STEP_ERR);
      end
   end

   assign win_end_s = (win_cnt_r == WIN_LAST);

   // Edge count including any step in this cycle, saturating.
   always_comb begin
      edge_inc_s = edge_cnt_r;
      if (valid_step_s && (edge_cnt_r != SPEED_MAX)) begin
         edge_inc_s = edge_cnt_r + SPEED_W'(1);
      end else begin
         edge_inc_s = edge_cnt_r;
      end
   end

   // Speed window: publish the edge count in the terminal cycle and restart.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         win_cnt_r     <= {WIN_W{1'b0}};
         edge_cnt_r    <= {SPEED_W{1'b0}};
         speed_r       <= {SPEED_W{1'b0}};
         speed_valid_r <= 1'b0;
      end else if (win_end_s) begin
         win_cnt_r     <= {WIN_W{1'b0}};
         edge_cnt_r    <= {SPEED_W{1'b0}};
         speed_r       <= edge_inc_s;
         speed_valid_r <= 1'b1;
      end else begin
         win_cnt_r     <= win_cnt_r + WIN_W'(1);
         edge_cnt_r    <= edge_inc_s;
         speed_valid_r <= 1'b0;
      end
   end

   // Consecutive idle windows while commanded; any edge or a stop command
   // restarts the count.
   always_comb begin
      stall_cnt_nx_s = stall_cnt_r;
      if (motor_signal != MOTOR_CW) begin
         stall_cnt_nx_s = {STALL_W{1'b0}};
      end else if (win_end_s) begin
         if (edge_inc_s != {SPEED_W{1'b0}}) begin
            stall_cnt_nx_s = {STALL_W{1'b0}};
         end else if (stall_cnt_r != STALL_LIM) begin
            stall_cnt_nx_s = stall_cnt_r + STALL_W'(1);
         end else begin
            stall_cnt_nx_s = stall_cnt_r;
         end
      end else begin
         stall_cnt_nx_s = stall_cnt_r;
      end
   end

   // Stall counter and flag.
   always_ff @(posedge clk) begin
      if (n_rst) begin
         stall_cnt_r <= {STALL_W{1'b0}};
         stall_r     <= 1'b0;
      end else begin
         stall_cnt_r <= stall_cnt_nx_s;
         stall_r     <= (motor_signal == MOTOR_CW) && (stall_cnt_nx_s == STALL_LIM);
      end
   end

   assign position    = position_r;
   assign dir         = dir_r;
   assign speed       = speed_r;
   assign speed_valid = speed_valid_r;
   assign stall       = stall_r;
   assign err         = err_r;

endmodule

// File: tb/tb_motor_encoder_decoder.sv
module tb_motor_encoder_decoder;

   localparam int CNT_W   = 16;
   localparam int CNT_W_S = 4;
   localparam int SPEED_W = 16;
   localparam int WIN     = 100;
   localparam int STALL_N = 2;
   localparam int FILT    = 3;

   logic clk;
   logic n_rst, enc_a, enc_b, motor_signal, clr;
   logic enc_z;
   logic [CNT_W-1:0]   position;
   logic               dir, speed_valid, stall, err;
   logic [SPEED_W-1:0] speed;
   logic [CNT_W_S-1:0] w_position;
   logic               w_dir, w_speed_valid, w_stall, w_err;
   logic [SPEED_W-1:0] w_speed;

   int checks = 0;
   int errors = 0;

   // reference model state
   logic [1:0]         gray_lvl [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
   int                 m_idx;
   logic [CNT_W-1:0]   m_pos;
   logic               m_dir;
   int                 m_err;

   // monitors
   int                 edges = 0;
   int                 err_cnt = 0;
   int                 sv_cnt = 0;
   int                 sv_bad = 0;
   logic [SPEED_W-1:0] sv_speed = '0;

   motor_encoder_decoder #(.CNT_W(CNT_W), .SPEED_W(SPEED_W), .WINDOW_CYCLES(WIN),
                           .STALL_WINDOWS(STALL_N), .FILT_LEN(FILT)) dut (
      .clk(clk), .n_rst(n_rst), .enc_a(enc_a), .enc_b(enc_b),
`ifdef ENC_INDEX_EN
      .enc_z(enc_z),
`endif
      .motor_signal(motor_signal), .clr(clr), .position(position), .dir(dir),
      .speed(speed), .speed_valid(speed_valid), .stall(stall), .err(err)
   );

   // narrow-counter instance used to reach the sign boundary quickly
   motor_encoder_decoder #(.CNT_W(CNT_W_S), .SPEED_W(SPEED_W), .WINDOW_CYCLES(WIN),
                           .STALL_WINDOWS(STALL_N), .FILT_LEN(FILT)) dut_w (
      .clk(clk), .n_rst(n_rst), .enc_a(enc_a), .enc_b(enc_b),
`ifdef ENC_INDEX_EN
      .enc_z(enc_z),
`endif
      .motor_signal(motor_signal), .clr(clr), .position(w_position), .dir(w_dir),
      .speed(w_speed), .speed_valid(w_speed_valid), .stall(w_stall), .err(w_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // clock edges since reset release
   always @(posedge clk) begin
      if (n_rst) edges <= 0;
      else       edges <= edges + 1;
   end

   // pulse monitors sampled on the falling edge
   always @(negedge clk) begin
      if (err === 1'b1) err_cnt <= err_cnt + 1;
      if (speed_valid === 1'b1) begin
         sv_cnt   <= sv_cnt + 1;
         sv_speed <= speed;
         if ((edges == 0) || ((edges % WIN) != 0)) sv_bad <= sv_bad + 1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int phase_of(input logic [1:0] lvl);
      for (int i = 0; i < 4; i++) if (gray_lvl[i] == lvl) return i;
      return 0;
   endfunction

   task automatic do_reset(input logic [1:0] lvl, input logic mot);
      n_rst = 1'b1; clr = 1'b0; motor_signal = mot; enc_z = 1'b0;
      {enc_a, enc_b} = lvl;
      tick(3);
      n_rst = 1'b0;
      tick(8);
      m_idx = phase_of(lvl); m_pos = '0; m_dir = 1'b0;
   endtask

   // move the encoder by delta phases (1 fwd, 3 rev, 2 illegal) and update model
   task automatic move(input int delta, input int hold);
      m_idx = (m_idx + delta) % 4;
      {enc_a, enc_b} = gray_lvl[m_idx];
      if (delta == 1) begin m_pos = m_pos + 16'd1; m_dir = 1'b1; end
      else if (delta == 3) begin m_pos = m_pos - 16'd1; m_dir = 1'b0; end
      else if (delta == 2) m_err++;
      tick(hold);
   endtask

   task automatic test_reset;
      n_rst = 1'b1; clr = 1'b0; motor_signal = 1'b1; enc_z = 1'b0;
      enc_a = 1'($urandom_range(0, 1)); enc_b = 1'($urandom_range(0, 1));
      tick(4);
      checks++; if (position !== 16'h0000) begin errors++; $display("FAIL reset_position: got %h expected 0000", position); end
      checks++; if (dir !== 1'b0) begin errors++; $display("FAIL reset_dir: got %b expected 0", dir); end
      checks++; if (speed !== 16'h0000) begin errors++; $display("FAIL reset_speed: got %h expected 0000", speed); end
      checks++; if (speed_valid !== 1'b0) begin errors++; $display("FAIL reset_speed_valid: got %b expected 0", speed_valid); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
   endtask

   task automatic test_forward;
      int e0;
      do_reset(2'b00, 1'b0);
      e0 = err_cnt;
      // first step: filtered after 5 cycles, position one cycle later
      m_idx = 1; {enc_a, enc_b} = gray_lvl[1];
      tick(5);
      checks++; if (position !== 16'h0000) begin errors++; $display("FAIL fwd_latency_early: got %h expected 0000", position); end
      tick(1);
      checks++; if (position !== 16'h0001) begin errors++; $display("FAIL fwd_latency_step: got %h expected 0001", position); end
      m_pos = 16'd1; m_dir = 1'b1;
      tick(4);
      move(1, 10); move(1, 10); move(1, 10);
      checks++; if (position !== 16'h0004) begin errors++; $display("FAIL fwd_position: got %h expected 0004", position); end
      checks++; if (dir !== 1'b1) begin errors++; $display("FAIL fwd_dir: got %b expected 1", dir); end
      checks++; if (err_cnt != e0) begin errors++; $display("FAIL fwd_no_err: got %0d err pulses expected 0", err_cnt - e0); end
   endtask

   task automatic test_reverse;
      do_reset(2'b00, 1'b0);
      move(3, 10);
      checks++; if (position !== 16'hFFFF) begin errors++; $display("FAIL rev_position: got %h expected ffff", position); end
      checks++; if (dir !== 1'b0) begin errors++; $display("FAIL rev_dir: got %b expected 0", dir); end
      checks++; if (w_position !== 4'hF) begin errors++; $display("FAIL rev_position_narrow: got %h expected f", w_position); end
   endtask

   task automatic test_wrap;
      do_reset(2'b00, 1'b0);
      for (int i = 0; i < 7; i++) move(1, 8);
      checks++; if (w_position !== 4'h7) begin errors++; $display("FAIL wrap_narrow_max: got %h expected 7", w_position); end
      move(1, 8);
      checks++; if (w_position !== 4'h8) begin errors++; $display("FAIL wrap_narrow_min: got %h expected 8", w_position); end
      checks++; if (position !== m_pos) begin errors++; $display("FAIL wrap_position: got %h expected %h", position, m_pos); end
   endtask

   task automatic test_err;
      int e0;
      do_reset(2'b00, 1'b0);
      e0 = err_cnt;
      move(2, 10);
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL err_pulse_cycles: got %0d expected 1", err_cnt - e0); end
      checks++; if (position !== 16'h0000) begin errors++; $display("FAIL err_position: got %h expected 0000", position); end
      move(1, 10);
      checks++; if (position !== 16'h0001) begin errors++; $display("FAIL err_next_step: got %h expected 0001", position); end
      checks++; if (dir !== 1'b1) begin errors++; $display("FAIL err_next_dir: got %b expected 1", dir); end
   endtask

   task automatic test_glitch;
      int e0;
      logic [CNT_W-1:0] p0;
      e0 = err_cnt; p0 = m_pos;
      enc_a = ~enc_a; tick(2); enc_a = ~enc_a; tick(10);
      checks++; if (position !== p0) begin errors++; $display("FAIL glitch_position: got %h expected %h", position, p0); end
      checks++; if (err_cnt != e0) begin errors++; $display("FAIL glitch_err: got %0d expected 0", err_cnt - e0); end
   endtask

   task automatic test_clr_step;
      do_reset(2'b00, 1'b0);
      move(1, 10); move(1, 10); move(3, 10);
      checks++; if (position !== 16'h0001 || dir !== 1'b0) begin errors++; $display("FAIL clr_setup: got %h/%b expected 0001/0", position, dir); end
      // forward step registers 6 edges after the drive; clr on exactly that edge
      m_idx = (m_idx + 1) % 4; {enc_a, enc_b} = gray_lvl[m_idx];
      tick(5);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      m_pos = '0; m_dir = 1'b1;
      checks++; if (position !== 16'h0000) begin errors++; $display("FAIL clr_wins_position: got %h expected 0000", position); end
      checks++; if (dir !== 1'b1) begin errors++; $display("FAIL clr_step_dir: got %b expected 1", dir); end
      tick(6);
      checks++; if (position !== 16'h0000) begin errors++; $display("FAIL clr_hold: got %h expected 0000", position); end
   endtask

   task automatic test_speed;
      int s0;
      do_reset(2'b00, 1'b0);
      s0 = sv_cnt;
      for (int i = 0; i < 7; i++) move(1, 10);
      tick(102 - edges);
      checks++; if (sv_cnt - s0 != 1) begin errors++; $display("FAIL speed_valid_pulses: got %0d expected 1", sv_cnt - s0); end
      checks++; if (sv_speed !== 16'd7) begin errors++; $display("FAIL speed_seven: got %0d expected 7", sv_speed); end
      // step landing exactly in the terminal cycle of the second window
      tick(194 - edges);
      move(1, 202 - edges);
      checks++; if (sv_speed !== 16'd1) begin errors++; $display("FAIL speed_terminal_step: got %0d expected 1", sv_speed); end
      tick(302 - edges);
      checks++; if (sv_speed !== 16'd0) begin errors++; $display("FAIL speed_idle_window: got %0d expected 0", sv_speed); end
      checks++; if (sv_cnt - s0 != 3) begin errors++; $display("FAIL speed_valid_count: got %0d expected 3", sv_cnt - s0); end
      checks++; if (sv_bad != 0) begin errors++; $display("FAIL speed_valid_phase: got %0d off-phase pulses expected 0", sv_bad); end
   endtask

   task automatic test_stall;
      do_reset(2'b00, 1'b1);
      tick(199 - edges);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_early: got %b expected 0", stall); end
      tick(1);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_second_window: got %b expected 1", stall); end
      motor_signal = 1'b0;
      tick(1);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_cleared: got %b expected 0", stall); end
      motor_signal = 1'b1;
      tick(310 - edges);
      move(1, 10);
      tick(400 - edges);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_edge_resets_400: got %b expected 0", stall); end
      tick(500 - edges);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_edge_resets_500: got %b expected 0", stall); end
      tick(600 - edges);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_again_600: got %b expected 1", stall); end
      motor_signal = 1'b0;
      tick(2);
   endtask

   task automatic test_random;
      int e0, r;
      do_reset(gray_lvl[$urandom_range(0, 3)], 1'b0);
      e0 = err_cnt; m_err = 0;
      for (int i = 0; i < 40; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4)      move(1, $urandom_range(8, 15));
         else if (r < 8) move(3, $urandom_range(8, 15));
         else if (r == 8) move(2, $urandom_range(8, 15));
         else begin
            enc_b = ~enc_b; tick($urandom_range(1, 2)); enc_b = ~enc_b; tick(10);
         end
         checks++; if (position !== m_pos) begin errors++; $display("FAIL rnd_position[%0d]: got %h expected %h", i, position, m_pos); end
         checks++; if (w_position !== m_pos[CNT_W_S-1:0]) begin errors++; $display("FAIL rnd_position_narrow[%0d]: got %h expected %h", i, w_position, m_pos[CNT_W_S-1:0]); end
         checks++; if (dir !== m_dir) begin errors++; $display("FAIL rnd_dir[%0d]: got %b expected %b", i, dir, m_dir); end
      end
      tick(2);
      checks++; if (err_cnt - e0 != m_err) begin errors++; $display("FAIL rnd_err_count: got %0d expected %0d", err_cnt - e0, m_err); end
   endtask

   task automatic test_reset_mid;
      int e0;
      m_idx = 2; {enc_a, enc_b} = gray_lvl[2];
      tick(10);
      e0 = err_cnt;
      n_rst = 1'b1; tick(3); n_rst = 1'b0; tick(20);
      m_pos = '0; m_dir = 1'b0;
      checks++; if (position !== 16'h0000) begin errors++; $display("FAIL midreset_position: got %h expected 0000", position); end
      checks++; if (err_cnt != e0) begin errors++; $display("FAIL midreset_err: got %0d expected 0", err_cnt - e0); end
      move(1, 10);
      checks++; if (position !== 16'h0001) begin errors++; $display("FAIL midreset_step: got %h expected 0001", position); end
   endtask

`ifdef ENC_INDEX_EN
   task automatic test_index;
      do_reset(2'b00, 1'b0);
      for (int i = 0; i < 25; i++) move(1, 8);
      checks++; if (position !== 16'd25) begin errors++; $display("FAIL index_setup: got %0d expected 25", position); end
      enc_z = 1'b1; tick(10);
      checks++; if (position !== 16'h0000) begin errors++; $display("FAIL index_clear: got %h expected 0000", position); end
      enc_z = 1'b0; tick(10);
   endtask
`endif

   initial begin
      n_rst = 1'b1; enc_a = 1'b0; enc_b = 1'b0; enc_z = 1'b0;
      motor_signal = 1'b0; clr = 1'b0;
      m_idx = 0; m_pos = '0; m_dir = 1'b0; m_err = 0;
      test_reset();
      test_forward();
      test_reverse();
      test_wrap();
      test_err();
      test_glitch();
      test_clr_step();
      test_speed();
      test_stall();
      test_random();
      test_reset_mid();
`ifdef ENC_INDEX_EN
      test_index();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
